cmd_queue: RTL

- Buffers 16-bit command words arriving from the UART wrapper and issues them one at a time to the command processor.
- Holds the issued word stable until the command completes, so the processor can keep sampling cmd[1:0] during a move.
- Owns the UART transmitter and sends the completion byte 0xA5 for each finished command.
- Sits between UART_Wrapper and cmd_proc; lets the host pipeline up to DEPTH commands without waiting for each response.

---
 rtl/maze_pkg.sv | 22 ++
 rtl/cmd_fifo.sv | 58 +++++
 rtl/cmd_queue.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze command path.
// Holds the command-queue FSM state type, the default response bytes and
// the command opcode encodings used by the benches.
package maze_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        BUSY,
        RESP,
        TXW
    } state_t;

    localparam logic [7:0] ACK_BYTE_DEFAULT = 8'hA5;
    localparam logic [7:0] ERR_BYTE_DEFAULT = 8'hEE;

    localparam logic [2:0] CAL   = 3'b000;
    localparam logic [2:0] HDNG  = 3'b001;
    localparam logic [2:0] MOVE  = 3'b010;
    localparam logic [2:0] SOLVE = 3'b011;

endpackage

// File: rtl/cmd_fifo.sv
// DEPTH x 16 synchronous FIFO with push, pop and synchronous flush.
// Read data is the current head (combinational read of the storage array).
// Push and pop in the same cycle are both honoured; callers qualify them.
module cmd_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [15:0]              i_wdata,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [15:0]              o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; a push coinciding with flush is discarded.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/cmd_queue.sv
// Command queue between UART_Wrapper and cmd_proc.
// Buffers incoming command words, issues them one at a time, holds the
// issued word until completion and sends ACK_BYTE when each command ends.
// Optional macro CMD_QUEUE_ERR_RESP_EN: dropped words also trigger one
// merged ERR_BYTE transmission whenever the transmitter is free.
module cmd_queue
    import maze_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [7:0]  ACK_BYTE = ACK_BYTE_DEFAULT
`ifdef CMD_QUEUE_ERR_RESP_EN
    ,
    parameter logic [7:0]  ERR_BYTE = ERR_BYTE_DEFAULT
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            in_cmd,
    input  logic                   in_rdy,
    output logic                   clr_in_rdy,
    output logic [15:0]            cmd,
    output logic                   cmd_rdy,
    input  logic                   clr_cmd_rdy,
    input  logic                   send_resp,
    output logic [7:0]             resp,
    output logic                   trmt,
    input  logic                   tx_done,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] q_cnt,
    output logic                   ovfl
);

    state_t r_state;
    state_t w_next;

    logic [15:0] r_cmd;
    logic [7:0]  r_resp;
    logic        r_trmt;
    logic        r_tx_busy;
    logic        r_ovfl;

    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic        w_ack_go;
    logic        w_err_go;
    logic        w_full;
    logic        w_empty;
    logic [15:0] w_head;

    cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (in_cmd),
        .i_pop   (w_pop),
        .i_flush (flush),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (q_cnt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state: issue, await acceptance, await completion, send ACK, await tx.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_pop) w_next = ISSUE;
            ISSUE:   if (clr_cmd_rdy) w_next = send_resp ? RESP : BUSY;
            BUSY:    if (send_resp) w_next = RESP;
            RESP:    if (w_ack_go) w_next = TXW;
            TXW:     if (tx_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Per-cycle control strobes for the FIFO and the transmitter.
    always_comb begin
        w_pop    = 1'b0;
        w_push   = 1'b0;
        w_drop   = 1'b0;
        w_ack_go = 1'b0;
        // Flush suppresses the pop so a flushed word is never issued.
        w_pop    = (r_state == IDLE) && !w_empty && !flush;
        // A full FIFO still accepts a word when the head leaves this cycle.
        w_push   = in_rdy && !flush && (!w_full || w_pop);
        w_drop   = in_rdy && !flush && w_full && !w_pop;
        w_ack_go = (r_state == RESP) && !r_tx_busy;
    end

`ifdef CMD_QUEUE_ERR_RESP_EN
    logic r_err_pend;

    // Pending error byte; repeated drops merge until the byte is sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err_pend <= 1'b0;
        else        r_err_pend <= w_drop || (r_err_pend && !w_err_go);
    end

    // ACK wins a tie; the error byte goes out once the transmitter frees.
    assign w_err_go = r_err_pend && !r_tx_busy && !w_ack_go;
`else
    assign w_err_go = 1'b0;
`endif

    // Issued command word; changes only when the head is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_cmd <= '0;
        else if (w_pop) r_cmd <= w_head;
    end

    // Transmit pulse, response byte and transmitter-busy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trmt    <= 1'b0;
            r_resp    <= '0;
            r_tx_busy <= 1'b0;
        end else begin
            r_trmt <= w_ack_go || w_err_go;
            if (w_ack_go) r_resp <= ACK_BYTE;
`ifdef CMD_QUEUE_ERR_RESP_EN
            else if (w_err_go) r_resp <= ERR_BYTE;
`endif
            if (w_ack_go || w_err_go) r_tx_busy <= 1'b1;
            else if (tx_done)         r_tx_busy <= 1'b0;
        end
    end

    // Sticky overflow flag, cleared only by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_ovfl <= 1'b0;
        else if (flush)  r_ovfl <= 1'b0;
        else if (w_drop) r_ovfl <= 1'b1;
    end

    // Every presented word is consumed, stored or dropped, in its own cycle.
    assign clr_in_rdy = in_rdy;
    assign cmd        = r_cmd;
    assign cmd_rdy    = (r_state == ISSUE);
    assign resp       = r_resp;
    assign trmt       = r_trmt;
    assign ovfl       = r_ovfl;

endmodule
